// File: rtl/light_mode_sequencer_if.sv
// Handshake/status bundle between the mode sequencer and its controller.
// master: sequencer side (drives mode/step status, receives start/pause).
// slave:  controller side (drives start/pause, observes status).
interface light_mode_sequencer_if;
   logic       start;
   logic       pause;
   logic [1:0] S;
   logic       step_tick;
   logic [3:0] step_idx;
   logic       rep;
   logic       busy;
   logic       done;

   modport master (
      input  start, pause,
      output S, step_tick, step_idx, rep, busy, done
   );

   modport slave (
      output start, pause,
      input  S, step_tick, step_idx, rep, busy, done
   );
endinterface

// File: rtl/light_mode_sequencer.sv
// Mode sequencer for the 8-lamp pattern generator: steps S through 0..3, REPEATS reps each.
// Latency: first step_tick TICK_DIV clks after RUN entry; all outputs registered.
// Backpressure: pause freezes prescaler and counters; LIGHT_MODE_LOOP_EN makes the show loop forever.
module light_mode_sequencer #(
   parameter int TICK_DIV = 50_000_000,
   parameter int LEN0     = 16,
   parameter int LEN1     = 8,
   parameter int LEN2     = 9,
   parameter int LEN3     = 8,
   parameter int REPEATS  = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   light_mode_sequencer_if.master   bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] R_LAST = RW'(REPEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      s_q, s_d;
   logic [3:0]      idx_q, idx_d;
   logic [RW-1:0]   rep_q, rep_d;
   logic            tick_q, tick_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [3:0]      len_last;
   logic            tick_now;
   logic            last_idx;
   logic            last_rep;
   logic            run_end;
   logic            launch;

   // Last step index of the repetition for the mode currently selected.
   always_comb begin
      len_last = 4'(LEN0 - 1);
      case (s_q)
         2'd0:    len_last = 4'(LEN0 - 1);
         2'd1:    len_last = 4'(LEN1 - 1);
         2'd2:    len_last = 4'(LEN2 - 1);
         default: len_last = 4'(LEN3 - 1);
      endcase
   end

   // A step happens when the unpaused prescaler sits on its last count.
   always_comb begin
      tick_now = (state_q == ST_RUN) && !bus.pause && (presc_q == P_LAST);
      last_idx = (idx_q == len_last);
      last_rep = (rep_q == R_LAST);
      run_end  = last_idx && last_rep && (s_q == 2'd3);
      launch   = bus.start && (state_q != ST_RUN);
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start launches from IDLE/DONE, final step of mode 3 ends the show.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (tick_now && run_end) begin
`ifdef LIGHT_MODE_LOOP_EN
               state_d = ST_RUN;
`else
               state_d = ST_DONE;
`endif
            end
         end
         ST_DONE: begin
            if (bus.start) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values: prescaler, step/rep/mode counters and status flags.
   always_comb begin
      presc_d = presc_q;
      s_d     = s_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      tick_d  = 1'b0;
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
      if (launch) begin
         presc_d = '0;
         s_d     = 2'd0;
         idx_d   = 4'd0;
         rep_d   = '0;
      end else if ((state_q == ST_RUN) && !bus.pause) begin
         presc_d = tick_now ? '0 : presc_q + 1'b1;
         if (tick_now) begin
            tick_d = 1'b1;
            if (!last_idx) begin
               idx_d = idx_q + 4'd1;
            end else begin
               idx_d = 4'd0;
               if (!last_rep) begin
                  rep_d = rep_q + 1'b1;
               end else begin
                  rep_d = '0;
                  if (s_q != 2'd3) begin
                     s_d = s_q + 2'd1;
                  end else begin
`ifdef LIGHT_MODE_LOOP_EN
                     s_d = 2'd0;
`else
                     s_d = 2'd3;
`endif
                  end
               end
            end
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         s_q     <= 2'd0;
         idx_q   <= 4'd0;
         rep_q   <= '0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.S         = s_q;
   assign bus.step_tick = tick_q;
   assign bus.step_idx  = idx_q;
   assign bus.rep       = rep_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_light_mode_sequencer.sv
// Bench for light_mode_sequencer: step-count model plus targeted literal checks.
// Latency: outputs compared on every falling edge against the model.
// Backpressure: pause driven both deterministically and randomly.
module tb_light_mode_sequencer;

   localparam int TD    = 4;
   localparam int REPS  = 2;
   localparam int TOTAL = 82;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   light_mode_sequencer_if bus();

   light_mode_sequencer #(.TICK_DIV(TD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int len_of(input int s);
      case (s)
         0:       return 16;
         1:       return 8;
         2:       return 9;
         default: return 8;
      endcase
   endfunction

   // Map a number of completed steps onto (mode, repetition, index).
   function automatic void exp_pos(input int k, output int s, output int r, output int i);
      int rem;
      s = 3; r = 0; i = 0;
      if (k >= TOTAL) return;
      rem = k;
      for (int m = 0; m < 4; m++) begin
         if (rem < REPS * len_of(m)) begin
            s = m;
            r = rem / len_of(m);
            i = rem % len_of(m);
            return;
         end
         rem -= REPS * len_of(m);
      end
   endfunction

   // Model: 0 idle, 1 run, 2 done; counts unpaused run cycles and completed steps.
   int m_st  = 0;
   int m_act = 0;
   int m_k   = 0;
   bit m_tick = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_st = 0; m_act = 0; m_k = 0; m_tick = 1'b0;
      end else begin
         m_tick = 1'b0;
         if (m_st == 1) begin
            if (!bus.pause) begin
               m_act++;
               if (m_act % TD == 0) begin
                  m_tick = 1'b1;
                  m_k++;
                  if (m_k == TOTAL) begin
`ifdef LIGHT_MODE_LOOP_EN
                     m_k = 0;
`else
                     m_st = 2;
`endif
                  end
               end
            end
         end else if (bus.start) begin
            m_st = 1; m_act = 0; m_k = 0;
         end
      end
   end

   always @(negedge clk) begin : cmp
      int s, r, i;
      if (chk_en) begin
         exp_pos(m_k, s, r, i);
         chk("S", bus.S, s);
         chk("step_idx", bus.step_idx, i);
         chk("rep", bus.rep, r & 1);
         chk("step_tick", bus.step_tick, m_tick);
         chk("busy", bus.busy, (m_st == 1) ? 1 : 0);
         chk("done", bus.done, (m_st == 2) ? 1 : 0);
      end
   end

   int cyc, nt, ptick;
   int cnt [4];

   // mode: 0 plain, 1 pause at S=0/idx=5 with start held, 2 random pause/start
   task automatic run_to_done(input int mode);
      int prev;
      bit paused;
      bus.start = 1'b1;
      @(negedge clk);
      chk("launch_S", bus.S, 0);
      chk("launch_busy", bus.busy, 1);
      chk("launch_done", bus.done, 0);
      if (mode == 0) bus.start = 1'b0;
      cyc = 0; nt = 0; ptick = 0; paused = 1'b0;
      for (int m = 0; m < 4; m++) cnt[m] = 0;
      prev = bus.S;
      while (!bus.done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bus.step_tick) begin nt++; cnt[prev]++; end
         prev = bus.S;
         if (mode == 1) bus.start = (m_k < TOTAL - 2);
         if (mode == 2) begin
            bus.start = (m_k < TOTAL - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.pause = ($urandom_range(0, 3) == 0);
         end
         if (mode == 1 && !paused && bus.S == 2'd0 && bus.step_idx == 4'd5) begin
            bus.pause = 1'b1;
            repeat (20) begin
               @(negedge clk);
               cyc++;
               ptick += bus.step_tick;
            end
            chk("pause_idx_held", bus.step_idx, 5);
            chk("pause_no_ticks", ptick, 0);
            bus.pause = 1'b0;
            paused = 1'b1;
         end
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      chk("run_reached_done", bus.done, 1);
   endtask

   initial begin
      int found;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      #1 reset_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Idle after reset: no activity without start.
      nt = 0;
      repeat (50) begin
         @(negedge clk);
         nt += bus.step_tick;
      end
      chk("idle_ticks", nt, 0);
      chk("idle_S", bus.S, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);

`ifndef LIGHT_MODE_LOOP_EN
      // Full uninterrupted run.
      run_to_done(0);
      chk("full_cycles", cyc, 328);
      chk("full_ticks", nt, 82);
      chk("full_ticks_S0", cnt[0], 32);
      chk("full_ticks_S1", cnt[1], 16);
      chk("full_ticks_S2", cnt[2], 18);
      chk("full_ticks_S3", cnt[3], 16);
      chk("done_S", bus.S, 3);
      chk("done_idx", bus.step_idx, 0);
      chk("done_busy", bus.busy, 0);
      repeat (5) @(negedge clk);
      chk("done_holds", bus.done, 1);

      // Restart from DONE, start held during RUN, 20-clk pause at S=0 idx=5.
      run_to_done(1);
      chk("pause_cycles", cyc, 348);
      chk("pause_run_ticks", nt, 82);

      // Randomised pause/start run.
      run_to_done(2);
      chk("rand_ticks", nt, 82);
      repeat (3) @(negedge clk);
`else
      // Looping build: tick 82 wraps to mode 0 and the run continues.
      bus.start = 1'b1;
      @(negedge clk);
      cyc = 0; nt = 0;
      while (nt < 82 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         nt += bus.step_tick;
         bus.start = 1'($urandom_range(0, 1));
      end
      bus.start = 1'b0;
      chk("loop_tick82_seen", nt, 82);
      chk("loop_S", bus.S, 0);
      chk("loop_rep", bus.rep, 0);
      chk("loop_idx", bus.step_idx, 0);
      chk("loop_busy", bus.busy, 1);
      chk("loop_done", bus.done, 0);
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(negedge clk);
         if (bus.step_tick) found = 1;
      end
      chk("loop_tick83_seen", found, 1);
      chk("loop_tick83_S", bus.S, 0);
      chk("loop_tick83_idx", bus.step_idx, 1);
      repeat (300) begin
         @(negedge clk);
         bus.pause = ($urandom_range(0, 3) == 0);
         bus.start = 1'($urandom_range(0, 1));
      end
      bus.pause = 1'b0;
      bus.start = 1'b0;
      chk("loop_never_done", bus.done, 0);
`endif

      // Asynchronous reset in mode 2, repetition 1.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         @(negedge clk);
         if (bus.S == 2'd2 && bus.rep == 1'b1) found = 1;
      end
      chk("reach_S2_rep1", found, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_S", bus.S, 0);
      chk("arst_idx", bus.step_idx, 0);
      chk("arst_rep", bus.rep, 0);
      chk("arst_tick", bus.step_tick, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_arst_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
